// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package nsa_pkg;

  // Width of one adder step; the datapath is built around a single 4-bit adder.
  localparam int NIB_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the nibble index counter.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/nsa_nibble_add.sv
// Combinational 4-bit carry-chain adder step: a4 + b4 + ci -> {co, s4}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module nsa_nibble_add
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic             ci,
  output logic [NIB_W-1:0] s4,
  output logic             co
);

  // Widen to 5 bits so the nibble carry-out falls out of the add directly.
  assign {co, s4} = {1'b0, a4} + {1'b0, b4} + {{NIB_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit adder, LSB nibble first; optional subtract via NIBBLE_SERIAL_SUB_EN.
// Latency: done pulses WIDTH/4 edges after the accepting edge; busy high for WIDTH/4 cycles.
// Backpressure: start is only honoured in IDLE/DONE; requests during RUN are dropped, not queued.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int IDX_W = (clog2(NIBS) < 1) ? 1 : clog2(NIBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;   // holds the effective B (already inverted for subtract)

  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic [NIB_W-1:0] a4;
  logic [NIB_W-1:0] b4;
  logic [NIB_W-1:0] s4;
  logic             co;

  // Subtract is folded into the operand capture: a - b = a + ~b + 1.
`ifdef NIBBLE_SERIAL_SUB_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub | cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  // Select the operand nibbles addressed by the current step index.
  always_comb begin
    a4 = '0;
    b4 = '0;
    for (int i = 0; i < NIBS; i++) begin
      if (idx == IDX_W'(i)) begin
        a4 = a_reg[i*NIB_W +: NIB_W];
        b4 = b_reg[i*NIB_W +: NIB_W];
      end
    end
  end

  nsa_nibble_add u_nibble_add (
    .a4 (a4),
    .b4 (b4),
    .ci (carry),
    .s4 (s4),
    .co (co)
  );

  // Controller FSM with registered handshake outputs, operand/sum registers and carry chain state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // done is a single-cycle pulse; drop it whether or not a new op starts.
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_reg <= a;
            b_reg <= b_in;
            carry <= cin_in;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBS; i++) begin
            if (idx == IDX_W'(i)) sum[i*NIB_W +: NIB_W] <= s4;
          end
          carry <= co;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= co;
            // Overflow: operands share a sign and the result sign differs from it.
            ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (s4[NIB_W-1] != a_reg[WIDTH-1]);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder against an arithmetic reference model.
// Covers directed corner cases, start handling in RUN/DONE, reset abort and random operands.
// Optional subtract cases are compiled in with NIBBLE_SERIAL_SUB_EN.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIBS  = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;
  logic             exp_ovf;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: whole-word arithmetic with one extra bit for the carry.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       input logic mcin, input logic msub);
    logic [WIDTH-1:0] beff;
    logic [WIDTH:0]   full;
    logic             ci;
    beff = msub ? ~mb : mb;
    ci   = msub ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, beff} + {{WIDTH{1'b0}}, ci};
    exp_sum  = full[WIDTH-1:0];
    exp_cout = full[WIDTH];
    exp_ovf  = (ma[WIDTH-1] == beff[WIDTH-1]) && (exp_sum[WIDTH-1] != ma[WIDTH-1]);
  endtask

  // Called at a negedge; drives one start cycle and returns at the following negedge.
  task automatic apply_start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                             input logic tcin, input logic tsub);
    a     = ta;
    b     = tb_;
    cin   = tcin;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub   = tsub;
`endif
    start = 1'b1;
    model(ta, tb_, tcin, tsub);
    @(negedge clk);
    start = 1'b0;
  endtask

  // elapsed = negedges already seen since the start negedge (all of them with busy=1).
  task automatic wait_done(input string tag, input int elapsed);
    int k;
    int bc;
    k  = elapsed;
    bc = elapsed - 1;
    while (!done && k < NIBS + 20) begin
      if (busy) bc++;
      @(negedge clk);
      k++;
    end
    check({tag, "_done"},    32'(done), 32'(1'b1));
    check({tag, "_latency"}, 32'(k - 1), 32'(NIBS));
    check({tag, "_busycyc"}, 32'(bc), 32'(NIBS));
    check({tag, "_sum"},     32'(sum), 32'(exp_sum));
    check({tag, "_cout"},    32'(cout), 32'(exp_cout));
    check({tag, "_ovf"},     32'(ovf), 32'(exp_ovf));
  endtask

  // Cycle after done: pulse must be gone and the result must hold.
  task automatic check_after(input string tag);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(done), 32'(1'b0));
    check({tag, "_idle_busy"}, 32'(busy), 32'(1'b0));
    check({tag, "_hold_sum"},  32'(sum), 32'(exp_sum));
  endtask

  initial begin
    int dcount;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             rs;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add.
    apply_start(16'h1234, 16'h1111, 1'b0, 1'b0);
    check("t1_exp_model", 32'(exp_sum), 32'h2345);
    wait_done("t1", 1);
    check_after("t1");

    // Carry ripples through every nibble.
    apply_start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done("t2", 1);
    check_after("t2");

    // Signed overflow cases.
    apply_start(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done("t3a", 1);
    check_after("t3a");
    apply_start(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_done("t3b", 1);
    check_after("t3b");

    // Start in RUN must be ignored; original operands produce the result.
    apply_start(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    a     = 16'hAAAA;
    b     = 16'hAAAA;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4a", 3);

    // Start in the DONE cycle is accepted back-to-back.
    apply_start(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_done("t4b", 1);
    check("t4b_value", 32'(sum), 32'h0003);
    check_after("t4b");

    // Reset mid-RUN after two nibbles: immediate clear, no done afterwards.
    apply_start(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum",  32'(sum),  32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    check("t5_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("t5_no_done", 32'(dcount), 32'd0);
    check("t5_sum_idle", 32'(sum), 32'd0);

`ifdef NIBBLE_SERIAL_SUB_EN
    apply_start(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done("t6a", 1);
    check("t6a_value", 32'(sum), 32'hFFFE);
    check_after("t6a");
    apply_start(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_done("t6b", 1);
    check("t6b_value", 32'(sum), 32'h0002);
    check_after("t6b");
`endif

    // Random operands, sometimes issuing the next start in the DONE cycle.
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
      rs = 1'($urandom);
`endif
      apply_start(ra, rb, rc, rs);
      wait_done("rnd", 1);
      if ($urandom_range(0, 1) == 0) check_after("rnd");
    end
    check_after("rnd_last");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
